mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
Parametrised successor to the team's 8-bit load/enable counter. Adds:
- configurable width and terminal value (modulo-N counting);
- up/down direction;
- wrap or saturate mode;
- synchronous clear;
- compare match, terminal-count output for cascading, and sticky overflow flag.

Used as a general timer/event counter and for building multi-digit (e.g. BCD) chains via tc.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL. Must be <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.
- RESET_VAL, 0, count value after reset. Must be <= MAX_VAL.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- clr  input  1  synchronous clear to 0 (also clears ovf).
- ld  input  1  synchronous load of din.
- din  input  WIDTH  load value.
- up  input  1  direction: 1 = increment, 0 = decrement.
- cmp_val  input  WIDTH  compare value.
- count  output  WIDTH  registered count.
- tc  output  1  combinational terminal count.
- evt  output  1  registered one-cycle bound-event pulse.
- match  output  1  combinational, count == cmp_val.
- ovf  output  1  registered sticky overflow flag.

Behaviour:
- Reset, asynchronous on rst=0 regardless of clk: count=RESET_VAL, evt=0, ovf=0. Outputs leave reset on the first rising clk edge after rst=1.
- Per-edge priority, highest first: clr > ld > en.
- clr=1: count<=0, ovf<=0, evt<=0. Ignores ld, en, up.
- ld=1 (clr=0): count<=din, evt<=0, ovf unchanged.
  - Takes effect regardless of en. This differs from the previous generation, where load was gated by enable.
  - din > MAX_VAL is clamped: count<=MAX_VAL.
- en=1 (clr=0, ld=0), up=1:
  - count<MAX_VAL: count<=count+1.
  - count==MAX_VAL: bound event; count<=0 (SATURATE=0) or holds MAX_VAL (SATURATE=1).
- en=1 (clr=0, ld=0), up=0:
  - count>0: count<=count-1.
  - count==0: bound event; count<=MAX_VAL (SATURATE=0) or holds 0 (SATURATE=1).
- en=0 with no clr/ld: count holds, evt<=0.
- Bound event: evt<=1 for exactly that cycle, ovf<=1. ovf stays 1 until clr or rst.
  - Back-to-back events (e.g. saturated with en held) keep evt high every cycle.
- evt deasserts on the next edge without an event.
- tc = en & ~clr & ~ld & ((up & count==MAX_VAL) | (~up & count==0)).
  - tc is high in the cycle before a bound event, so it can drive en of the next stage.
- match is purely combinational on count and cmp_val. Latency 0 from count.
- Count latency: 1 clk from a qualified input to count.
- Arithmetic: no intermediate value outside 0..MAX_VAL ever reaches count. Compares are unsigned, WIDTH bits.
- Changing up mid-count takes effect on the next edge. There is no hysteresis.
- Reset asserted mid-operation overrides everything immediately.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0; release rst, en=1, up=1 for 12 clks -> count 1..9,0,1,2. tc high while count==9; evt high one cycle after 9->0; ovf=1 thereafter.
2. Same config, up=0 from count=0, en=1 -> count 9,8,7. evt pulses on 0->9. Then clr=1 for one clk -> count=0, ovf=0, evt=0.
3. SATURATE=1, MAX_VAL=9; count to 9, hold en=1, up=1 for 3 clks -> count stays 9, evt=1 for each of the 3 cycles, ovf=1. Switch up=0 -> count 8, evt=0.
4. ld=1, din=4'hC with en=0 (MAX_VAL=9) -> count=9 (clamped) after 1 clk. Then ld=1 and clr=1 together -> count=0. Then ld=1, din=5, en=1 -> count=5 (load wins over count), no evt.
5. cmp_val=6, count up from 0 -> match high only while count==6. Assert rst=0 asynchronously mid-cycle at count=7 -> count=RESET_VAL and ovf=0 immediately, before the next clk edge.
6. Cascade two instances (WIDTH=4, MAX_VAL=9), stage-2 en = stage-1 tc; run 100 clks from 0 -> {stage2,stage1} reads 0,0 with stage-2 evt pulsing once at wrap 99->00.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N up/down counter with load, clear,
// wrap/saturate bound handling, compare match, cascade terminal count
// and a sticky overflow flag.
module mod_counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt,
    output logic             match,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_val;
    logic             evt_next;
    logic             ovf_next;
    logic             at_max;
    logic             at_zero;
    logic             at_bound;

    // A full-range terminal value needs no clamp; otherwise oversized
    // load values are pinned to the terminal value.
    generate
        if (MAX_VAL == {WIDTH{1'b1}}) begin : g_no_clamp
            assign load_val = din;
        end else begin : g_clamp
            assign load_val = (din > MAX_VAL) ? MAX_VAL : din;
        end
    endgenerate

    assign at_max   = (count == MAX_VAL);
    assign at_zero  = (count == ZERO);
    assign at_bound = up ? at_max : at_zero;

    // tc looks one edge ahead: it is high exactly when the coming edge
    // will be a bound event, so it can directly enable the next stage.
    assign tc    = en & ~clr & ~ld & at_bound;
    assign match = (count == cmp_val);

    // Next-state selection with clear > load > count priority.
    always_comb begin
        count_next = count;
        evt_next   = 1'b0;
        ovf_next   = ovf;
        if (clr) begin
            count_next = ZERO;
            ovf_next   = 1'b0;
        end else if (ld) begin
            count_next = load_val;
        end else if (en) begin
            if (at_bound) begin
                evt_next = 1'b1;
                ovf_next = 1'b1;
                if (SATURATE) begin
                    count_next = count;
                end else begin
                    count_next = up ? ZERO : MAX_VAL;
                end
            end else begin
                count_next = up ? (count + ONE) : (count - ONE);
            end
        end
    end

    // State registers; reset forces the configured start value at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VAL;
            evt   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            evt   <= evt_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed vectors for a wrapping counter, a saturating
// counter and a two-digit decimal cascade, checked through a scoreboard.
module tb_mod_counter;

    typedef struct {
        int    unit;
        bit    async_chk;
        int    tc;
        int    match;
        int    count;
        int    evt;
        int    ovf;
        int    tc2;
        int    match2;
        int    count2;
        int    evt2;
        int    ovf2;
        string name;
    } exp_t;

    exp_t sb[$];
    int   total_checks = 0;
    int   bad_checks   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapping unit: modulo-10, reset value 0.
    logic       w_rst, w_en, w_clr, w_ld, w_up;
    logic [3:0] w_din, w_cmp, w_count;
    logic       w_tc, w_evt, w_match, w_ovf;

    // Saturating unit: modulo-10, reset value 2.
    logic       s_rst, s_en, s_clr, s_ld, s_up;
    logic [3:0] s_din, s_cmp, s_count;
    logic       s_tc, s_evt, s_match, s_ovf;

    // Cascade: units digit drives the tens digit through tc.
    logic       c_rst, c_en, c_clr, c_ld, c_up;
    logic [3:0] c_din, c_cmp;
    logic [3:0] c1_count, c2_count;
    logic       c1_tc, c1_evt, c1_match, c1_ovf;
    logic       c2_tc, c2_evt, c2_match, c2_ovf;

    mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0)) dut_wrap (
        .clk(clk), .rst(w_rst), .en(w_en), .clr(w_clr), .ld(w_ld), .din(w_din),
        .up(w_up), .cmp_val(w_cmp), .count(w_count), .tc(w_tc), .evt(w_evt),
        .match(w_match), .ovf(w_ovf)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .RESET_VAL(4'd2)) dut_sat (
        .clk(clk), .rst(s_rst), .en(s_en), .clr(s_clr), .ld(s_ld), .din(s_din),
        .up(s_up), .cmp_val(s_cmp), .count(s_count), .tc(s_tc), .evt(s_evt),
        .match(s_match), .ovf(s_ovf)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0)) dut_units (
        .clk(clk), .rst(c_rst), .en(c_en), .clr(c_clr), .ld(c_ld), .din(c_din),
        .up(c_up), .cmp_val(c_cmp), .count(c1_count), .tc(c1_tc), .evt(c1_evt),
        .match(c1_match), .ovf(c1_ovf)
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0)) dut_tens (
        .clk(clk), .rst(c_rst), .en(c1_tc), .clr(c_clr), .ld(c_ld), .din(c_din),
        .up(c_up), .cmp_val(c_cmp), .count(c2_count), .tc(c2_tc), .evt(c2_evt),
        .match(c2_match), .ovf(c2_ovf)
    );

    function automatic int flag(input bit c);
        return c ? 1 : 0;
    endfunction

    // One comparison: counts it, reports it when it disagrees.
    task automatic check_output(input string what, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", what, act, exp);
        end
    endtask

    // Combinational outputs, sampled before the coming edge.
    task automatic check_comb(input exp_t e);
        case (e.unit)
            0: begin
                check_output({e.name, "/tc"}, {31'd0, w_tc}, e.tc);
                check_output({e.name, "/match"}, {31'd0, w_match}, e.match);
            end
            1: begin
                check_output({e.name, "/tc"}, {31'd0, s_tc}, e.tc);
                check_output({e.name, "/match"}, {31'd0, s_match}, e.match);
            end
            default: begin
                check_output({e.name, "/tc1"}, {31'd0, c1_tc}, e.tc);
                check_output({e.name, "/match1"}, {31'd0, c1_match}, e.match);
                check_output({e.name, "/tc2"}, {31'd0, c2_tc}, e.tc2);
                check_output({e.name, "/match2"}, {31'd0, c2_match}, e.match2);
            end
        endcase
    endtask

    // Registered outputs, sampled after the edge (or right after reset).
    task automatic check_registered(input exp_t e);
        case (e.unit)
            0: begin
                check_output({e.name, "/count"}, {28'd0, w_count}, e.count);
                check_output({e.name, "/evt"}, {31'd0, w_evt}, e.evt);
                check_output({e.name, "/ovf"}, {31'd0, w_ovf}, e.ovf);
            end
            1: begin
                check_output({e.name, "/count"}, {28'd0, s_count}, e.count);
                check_output({e.name, "/evt"}, {31'd0, s_evt}, e.evt);
                check_output({e.name, "/ovf"}, {31'd0, s_ovf}, e.ovf);
            end
            default: begin
                check_output({e.name, "/count1"}, {28'd0, c1_count}, e.count);
                check_output({e.name, "/evt1"}, {31'd0, c1_evt}, e.evt);
                check_output({e.name, "/ovf1"}, {31'd0, c1_ovf}, e.ovf);
                check_output({e.name, "/count2"}, {28'd0, c2_count}, e.count2);
                check_output({e.name, "/evt2"}, {31'd0, c2_evt}, e.evt2);
                check_output({e.name, "/ovf2"}, {31'd0, c2_ovf}, e.ovf2);
            end
        endcase
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the
    // unit should show before and after the next rising edge.
    task automatic apply_stimulus(input int u, input int clr_i, input int ld_i, input int din_i,
                                  input int en_i, input int up_i, input int cmp_i,
                                  input int e_tc, input int e_match, input int e_count,
                                  input int e_evt, input int e_ovf, input string name);
        exp_t e;
        @(negedge clk);
        if (u == 0) begin
            w_rst = 1'b1; w_clr = 1'(clr_i); w_ld = 1'(ld_i); w_din = 4'(din_i);
            w_en = 1'(en_i); w_up = 1'(up_i); w_cmp = 4'(cmp_i);
        end else begin
            s_rst = 1'b1; s_clr = 1'(clr_i); s_ld = 1'(ld_i); s_din = 4'(din_i);
            s_en = 1'(en_i); s_up = 1'(up_i); s_cmp = 4'(cmp_i);
        end
        e.unit = u; e.async_chk = 1'b0; e.name = name;
        e.tc = e_tc; e.match = e_match; e.count = e_count; e.evt = e_evt; e.ovf = e_ovf;
        e.tc2 = 0; e.match2 = 0; e.count2 = 0; e.evt2 = 0; e.ovf2 = 0;
        sb.push_back(e);
    endtask

    // Pull reset low mid-cycle; the unit must react before any edge.
    task automatic async_reset(input int u, input int e_count, input string name);
        exp_t e;
        @(negedge clk);
        if (u == 0) w_rst = 1'b0;
        else        s_rst = 1'b0;
        e.unit = u; e.async_chk = 1'b1; e.name = name;
        e.tc = 0; e.match = 0; e.count = e_count; e.evt = 0; e.ovf = 0;
        e.tc2 = 0; e.match2 = 0; e.count2 = 0; e.evt2 = 0; e.ovf2 = 0;
        sb.push_back(e);
    endtask

    // One cascade cycle starting from decimal value v.
    task automatic casc_step(input int v);
        exp_t e;
        @(negedge clk);
        c_rst = 1'b1;
        c_en  = 1'b1;
        e.unit = 2; e.async_chk = 1'b0; e.name = "cascade";
        e.tc     = flag(v % 10 == 9);
        e.match  = flag(v % 10 == 0);
        e.count  = (v + 1) % 10;
        e.evt    = flag(v % 10 == 9);
        e.ovf    = flag(v >= 9);
        e.tc2    = flag(v == 99);
        e.match2 = flag(v / 10 == 0);
        e.count2 = ((v + 1) / 10) % 10;
        e.evt2   = flag(v == 99);
        e.ovf2   = flag(v == 99);
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per driven cycle and compares it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.async_chk) begin
                    check_registered(e);
                end else begin
                    check_comb(e);
                    @(posedge clk);
                    #1;
                    check_registered(e);
                end
            end
        end
    end

    // Guard against a stuck run.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin : stimulus
        w_rst = 1'b0; w_en = 1'b0; w_clr = 1'b0; w_ld = 1'b0; w_up = 1'b1; w_din = 4'd0; w_cmp = 4'd0;
        s_rst = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_ld = 1'b0; s_up = 1'b1; s_din = 4'd0; s_cmp = 4'd0;
        c_rst = 1'b0; c_en = 1'b0; c_clr = 1'b0; c_ld = 1'b0; c_up = 1'b1; c_din = 4'd0; c_cmp = 4'd0;

        async_reset(0, 0, "rst_wrap");
        async_reset(1, 2, "rst_sat");

        // Count up through the wrap.
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(0, 0, 0, 0, 1, 1, 5, flag(k % 10 == 9), flag(k % 10 == 5),
                           (k + 1) % 10, flag(k == 9), flag(k >= 9), "up_wrap");
        end

        // Load clamp, clear over load, load over count.
        apply_stimulus(0, 0, 1, 12, 0, 1, 5, 0, 0, 9, 0, 1, "ld_clamp");
        apply_stimulus(0, 1, 1, 12, 1, 1, 5, 0, 0, 0, 0, 0, "clr_over_ld");
        apply_stimulus(0, 0, 1, 5, 1, 0, 5, 0, 0, 5, 0, 0, "ld_over_en");
        apply_stimulus(0, 1, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, "clr");

        // Count down through the wrap, hold, clear.
        apply_stimulus(0, 0, 0, 0, 1, 0, 5, 1, 0, 9, 1, 1, "dn_wrap");
        apply_stimulus(0, 0, 0, 0, 1, 0, 5, 0, 0, 8, 0, 1, "dn_8");
        apply_stimulus(0, 0, 0, 0, 1, 0, 5, 0, 0, 7, 0, 1, "dn_7");
        apply_stimulus(0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 0, 1, "hold");
        apply_stimulus(0, 1, 0, 0, 1, 0, 7, 0, 1, 0, 0, 0, "clr2");
        apply_stimulus(0, 0, 0, 0, 1, 0, 7, 1, 0, 9, 1, 1, "dn_wrap2");
        apply_stimulus(0, 1, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, "clr_evt");
        apply_stimulus(0, 0, 0, 0, 1, 0, 6, 1, 0, 9, 1, 1, "dn_wrap3");
        apply_stimulus(0, 0, 1, 0, 0, 1, 6, 0, 0, 0, 0, 1, "ld_zero");

        // Compare match, then an asynchronous reset at count 7.
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(0, 0, 0, 0, 1, 1, 6, 0, flag(k == 6), k + 1, 0, 1, "cmp_up");
        end
        async_reset(0, 0, "rst_mid");
        apply_stimulus(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, "post_rst");

        // Saturating unit: climb from its reset value, hold at the top.
        for (int k = 2; k < 9; k++) begin
            apply_stimulus(1, 0, 0, 0, 1, 1, 15, 0, 0, k + 1, 0, 0, "sat_up");
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 0, 0, 0, 1, 1, 9, 1, 1, 9, 1, 1, "sat_hold");
        end
        apply_stimulus(1, 0, 0, 0, 1, 0, 9, 0, 1, 8, 0, 1, "sat_turn");
        apply_stimulus(1, 0, 1, 0, 0, 0, 9, 0, 0, 0, 0, 1, "sat_ld0");
        apply_stimulus(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, "sat_bot");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "sat_idle");

        // Two-digit decimal cascade over a full 00..99 lap.
        for (int v = 0; v < 100; v++) begin
            casc_step(v);
        end

        @(negedge clk);
        @(negedge clk);
        check_output("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
